// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one single-port memory between the CPU (port 0) and a DMA/loader (port 1).
// Round-robin by default; define ARB_CPU_PRIORITY_EN to give the CPU fixed priority.
module mem_port_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          cpu_req_i,
    input  logic          cpu_we_i,
    input  logic [AW-1:0] cpu_addr_i,
    input  logic [DW-1:0] cpu_wdata_i,
    output logic [DW-1:0] cpu_rdata_o,
    output logic          cpu_ack_o,

    input  logic          dma_req_i,
    input  logic          dma_we_i,
    input  logic [AW-1:0] dma_addr_i,
    input  logic [DW-1:0] dma_wdata_i,
    output logic [DW-1:0] dma_rdata_o,
    output logic          dma_ack_o,

    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic          mem_read_o,
    output logic          mem_write_o,
    input  logic [DW-1:0] mem_rdata_i,

    output logic          gnt_dma_o,
    output logic          busy_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          weLatched_q, weLatched_d;
    logic          lastDma_q, lastDma_d;
    logic [AW-1:0] memAddr_q, memAddr_d;
    logic [DW-1:0] memWdata_q, memWdata_d;
    logic          memRead_q, memRead_d;
    logic          memWrite_q, memWrite_d;
    logic [DW-1:0] cpuRdata_q, cpuRdata_d;
    logic [DW-1:0] dmaRdata_q, dmaRdata_d;
    logic          cpuAck_q, cpuAck_d;
    logic          dmaAck_q, dmaAck_d;
    logic          gntDma_q, gntDma_d;
    logic          busy_q, busy_d;
    logic          pickDma;

    // lastDma_q resets to 1 so the CPU wins the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            weLatched_q <= 1'b0;
            lastDma_q   <= 1'b1;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            memRead_q   <= 1'b0;
            memWrite_q  <= 1'b0;
            cpuRdata_q  <= '0;
            dmaRdata_q  <= '0;
            cpuAck_q    <= 1'b0;
            dmaAck_q    <= 1'b0;
            gntDma_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            weLatched_q <= weLatched_d;
            lastDma_q   <= lastDma_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            memRead_q   <= memRead_d;
            memWrite_q  <= memWrite_d;
            cpuRdata_q  <= cpuRdata_d;
            dmaRdata_q  <= dmaRdata_d;
            cpuAck_q    <= cpuAck_d;
            dmaAck_q    <= dmaAck_d;
            gntDma_q    <= gntDma_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
`ifdef ARB_CPU_PRIORITY_EN
        pickDma = ~cpu_req_i;
`else
        pickDma = ~cpu_req_i | (dma_req_i & ~lastDma_q);
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cpu_req_i || dma_req_i) state_d = ACCESS;
            ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes and acks are computed one cycle ahead so every output leaves a flop.
    always_comb begin
        cnt_d       = cnt_q;
        weLatched_d = weLatched_q;
        lastDma_d   = lastDma_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        memRead_d   = 1'b0;
        memWrite_d  = 1'b0;
        cpuRdata_d  = cpuRdata_q;
        dmaRdata_d  = dmaRdata_q;
        cpuAck_d    = 1'b0;
        dmaAck_d    = 1'b0;
        gntDma_d    = gntDma_q;
        busy_d      = (state_d != IDLE);
        unique case (state_q)
            IDLE: begin
                if (cpu_req_i || dma_req_i) begin
                    gntDma_d    = pickDma;
                    weLatched_d = pickDma ? dma_we_i    : cpu_we_i;
                    memAddr_d   = pickDma ? dma_addr_i  : cpu_addr_i;
                    memWdata_d  = pickDma ? dma_wdata_i : cpu_wdata_i;
                    cnt_d       = CNT_INIT;
                    memRead_d   = ~weLatched_d;
                    memWrite_d  = weLatched_d;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!weLatched_q) begin
                        if (gntDma_q) dmaRdata_d = mem_rdata_i;
                        else          cpuRdata_d = mem_rdata_i;
                    end
                    cpuAck_d = ~gntDma_q;
                    dmaAck_d = gntDma_q;
                end else begin
                    cnt_d      = cnt_q - 4'd1;
                    memRead_d  = ~weLatched_q;
                    memWrite_d = weLatched_q;
                end
            end
            DONE:    lastDma_d = gntDma_q;
            default: ;
        endcase
    end

    assign cpu_rdata_o = cpuRdata_q;
    assign cpu_ack_o   = cpuAck_q;
    assign dma_rdata_o = dmaRdata_q;
    assign dma_ack_o   = dmaAck_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;
    assign mem_read_o  = memRead_q;
    assign mem_write_o = memWrite_q;
    assign gnt_dma_o   = gntDma_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a transaction-level model predicts each grant,
// and a negedge monitor compares strobes, acks, rdata, gnt_dma and busy every cycle.
module tb_mem_port_arbiter;

    localparam int AW      = 12;
    localparam int DW      = 16;
    localparam int MEM_LAT = 2;
    localparam int DEPTH   = 1 << AW;
    localparam logic [AW-1:0] RESET_TEST_ADDR = 12'hFFE;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        int            grantEdge;
    } expT;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          dropEarly;
    } reqT;

    logic          clk = 1'b0;
    logic          rstN;
    logic          cpuReq, cpuWe, cpuAck;
    logic [AW-1:0] cpuAddr;
    logic [DW-1:0] cpuWdata, cpuRdata;
    logic          dmaReq, dmaWe, dmaAck;
    logic [AW-1:0] dmaAddr;
    logic [DW-1:0] dmaWdata, dmaRdata;
    logic [AW-1:0] memAddr;
    logic [DW-1:0] memWdata, memRdata;
    logic          memRead, memWrite, gntDma, busy;

    logic [DW-1:0] memArr [DEPTH];
    logic [DW-1:0] refMem [DEPTH];
    bit            memLoaded = 1'b0;
    int            edgeCount = 0;

    expT expQ[$];
    reqT issueQ[$];

    int checks   = 0;
    int failures = 0;
    bit timeoutFlag     = 1'b0;
    bit timeoutReported = 1'b0;

    int   freeAt;
    logic lastDma;
    int   lastGrantEdge;
    logic active [2];
    logic dropEarly [2];
    int   raisedSteps [2];

    logic [DW-1:0] expCpuRd, expDmaRd;
    logic          expGnt;
    expT           monE;
    logic          monAct, monStrobe, monAck;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(MEM_LAT)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .cpu_req_i   (cpuReq),
        .cpu_we_i    (cpuWe),
        .cpu_addr_i  (cpuAddr),
        .cpu_wdata_i (cpuWdata),
        .cpu_rdata_o (cpuRdata),
        .cpu_ack_o   (cpuAck),
        .dma_req_i   (dmaReq),
        .dma_we_i    (dmaWe),
        .dma_addr_i  (dmaAddr),
        .dma_wdata_i (dmaWdata),
        .dma_rdata_o (dmaRdata),
        .dma_ack_o   (dmaAck),
        .mem_addr_o  (memAddr),
        .mem_wdata_o (memWdata),
        .mem_read_o  (memRead),
        .mem_write_o (memWrite),
        .mem_rdata_i (memRdata),
        .gnt_dma_o   (gntDma),
        .busy_o      (busy)
    );

    function automatic logic [DW-1:0] initWord(input int i);
        if (i == 'h010) return 16'hBEEF;
        return 16'((i * 40503) ^ 23130);
    endfunction

    // Memory array: filled on the first clock edge, then written whenever the strobe is high.
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < DEPTH; i++) memArr[i] <= initWord(i);
            memLoaded <= 1'b1;
        end else if (memWrite) begin
            memArr[memAddr] <= memWdata;
        end
    end

    assign memRdata = memArr[memAddr];

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at edge %0d: actual=%h required=%h", name, edgeCount, actual, expected);
        end
    endtask

    // Monitor: the front of expQ is the transaction currently owning the memory.
    always @(negedge clk) begin
        if (!rstN) begin
            expQ.delete();
            expCpuRd = '0;
            expDmaRd = '0;
            expGnt   = 1'b0;
            checkOutput("resetData", {4'h0, memAddr, memWdata, cpuRdata, dmaRdata}, 64'h0);
            checkOutput("resetCtrl", {58'h0, memRead, memWrite, cpuAck, dmaAck, gntDma, busy}, 64'h0);
        end else begin
            monAct    = 1'b0;
            monStrobe = 1'b0;
            monAck    = 1'b0;
            monE      = '{port: 1'b0, we: 1'b0, addr: '0, wdata: '0, rdata: '0, grantEdge: 0};
            if (expQ.size() > 0) begin
                monE      = expQ[0];
                monAct    = (edgeCount >= monE.grantEdge) && (edgeCount <= monE.grantEdge + MEM_LAT);
                monStrobe = monAct && (edgeCount <= monE.grantEdge + MEM_LAT - 1);
                monAck    = (edgeCount == monE.grantEdge + MEM_LAT);
                if (monAct) expGnt = monE.port;
            end
            checkOutput("strobes", {62'h0, memRead, memWrite},
                        monStrobe ? {62'h0, ~monE.we, monE.we} : 64'h0);
            if (monStrobe) begin
                checkOutput("memAddr", 64'(memAddr), 64'(monE.addr));
                checkOutput("memWdata", 64'(memWdata), 64'(monE.wdata));
            end
            if (monAck && !monE.we) begin
                if (monE.port) expDmaRd = monE.rdata;
                else           expCpuRd = monE.rdata;
            end
            checkOutput("acks", {62'h0, cpuAck, dmaAck},
                        monAck ? (monE.port ? 64'h1 : 64'h2) : 64'h0);
            checkOutput("busy", 64'(busy), 64'(monAct));
            checkOutput("gntDma", 64'(gntDma), 64'(expGnt));
            checkOutput("cpuRdata", 64'(cpuRdata), 64'(expCpuRd));
            checkOutput("dmaRdata", 64'(dmaRdata), 64'(expDmaRd));
            if (monAck) void'(expQ.pop_front());
            if (timeoutFlag && !timeoutReported) begin
                timeoutReported = 1'b1;
                checkOutput("waitBound", 64'h1, 64'h0);
            end
        end
    end

    // Reference model: one whole transaction per grant, memory busy for MEM_LAT+2 edges.
    task automatic modelStep();
        expT  e;
        logic pick;
        if (rstN && edgeCount >= freeAt && (cpuReq || dmaReq)) begin
`ifdef ARB_CPU_PRIORITY_EN
            pick = !cpuReq;
`else
            if (cpuReq && dmaReq) pick = (lastDma == 1'b0);
            else                  pick = dmaReq;
`endif
            e.port      = pick;
            e.we        = pick ? dmaWe    : cpuWe;
            e.addr      = pick ? dmaAddr  : cpuAddr;
            e.wdata     = pick ? dmaWdata : cpuWdata;
            e.rdata     = refMem[e.addr];
            e.grantEdge = edgeCount;
            if (e.we) refMem[e.addr] = e.wdata;
            freeAt        = edgeCount + MEM_LAT + 2;
            lastDma       = pick;
            lastGrantEdge = edgeCount;
            expQ.push_back(e);
        end
    endtask

    task automatic driveReq(input int p, input logic req, input reqT r);
        if (p == 0) begin
            cpuReq = req;
            if (req) begin cpuWe = r.we; cpuAddr = r.addr; cpuWdata = r.wdata; end
        end else begin
            dmaReq = req;
            if (req) begin dmaWe = r.we; dmaAddr = r.addr; dmaWdata = r.wdata; end
        end
    endtask

    function automatic int findIssue(input int p);
        foreach (issueQ[i]) if (int'(issueQ[i].port) == p) return i;
        return -1;
    endfunction

    function automatic int countIssue(input int p);
        int n = 0;
        foreach (issueQ[i]) if (int'(issueQ[i].port) == p) n++;
        return n;
    endfunction

    task automatic queueTxn(input int p, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic drop);
        reqT r;
        r.port      = 1'(p);
        r.we        = we;
        r.addr      = addr;
        r.wdata     = wdata;
        r.dropEarly = drop;
        issueQ.push_back(r);
    endtask

    // One clock of stimulus: model the edge just taken, then update both requesters.
    task automatic applyStimulus();
        logic ackSeen;
        int   idx;
        reqT  r;
        @(posedge clk);
        #1;
        modelStep();
        for (int p = 0; p < 2; p++) begin
            ackSeen = (p == 0) ? cpuAck : dmaAck;
            if (active[p]) begin
                raisedSteps[p]++;
                if (dropEarly[p] ? (raisedSteps[p] >= 1) : ackSeen) begin
                    active[p] = 1'b0;
                    r = '{port: 1'b0, we: 1'b0, addr: '0, wdata: '0, dropEarly: 1'b0};
                    driveReq(p, 1'b0, r);
                end
            end
            if (!active[p]) begin
                idx = findIssue(p);
                if (idx >= 0) begin
                    r = issueQ[idx];
                    issueQ.delete(idx);
                    active[p]      = 1'b1;
                    dropEarly[p]   = r.dropEarly;
                    raisedSteps[p] = 0;
                    driveReq(p, 1'b1, r);
                end
            end
        end
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while ((issueQ.size() > 0 || active[0] || active[1] || edgeCount < freeAt) && n < bound) begin
            applyStimulus();
            n++;
        end
        if (n >= bound) timeoutFlag = 1'b1;
    endtask

    initial begin
        int n;
        rstN = 1'b0;
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
        dmaReq = 1'b0; dmaWe = 1'b0; dmaAddr = '0; dmaWdata = '0;
        for (int i = 0; i < DEPTH; i++) refMem[i] = initWord(i);
        for (int p = 0; p < 2; p++) begin active[p] = 1'b0; dropEarly[p] = 1'b0; raisedSteps[p] = 0; end
        freeAt = 0;
        lastDma = 1'b1;
        lastGrantEdge = -1;
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;

        queueTxn(0, 1'b0, 12'h010, 16'h0BAD, 1'b0);
        waitIdle(50);
        queueTxn(1, 1'b1, 12'h0FF, 16'h1234, 1'b0);
        waitIdle(50);

        for (int k = 0; k < 4; k++) begin
            queueTxn(0, 1'b0, 12'(16 + k), 16'($urandom), 1'b0);
            queueTxn(1, k[0], 12'(32 + k), 16'($urandom), 1'b0);
        end
        waitIdle(200);

        queueTxn(0, 1'b0, 12'h0FF, 16'h7777, 1'b1);
        waitIdle(50);

        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (countIssue(p) < 2 && $urandom_range(0, 3) == 0)
                    queueTxn(p, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 63)), 16'($urandom), 1'b0);
            end
            applyStimulus();
        end
        waitIdle(400);

        queueTxn(0, 1'b1, RESET_TEST_ADDR, 16'hA5A5, 1'b0);
        lastGrantEdge = -1;
        n = 0;
        while (!(lastGrantEdge >= 0 && edgeCount == lastGrantEdge + 1) && n < 50) begin
            applyStimulus();
            n++;
        end
        if (n >= 50) timeoutFlag = 1'b1;
        rstN = 1'b0;
        cpuReq = 1'b0;
        dmaReq = 1'b0;
        issueQ.delete();
        for (int p = 0; p < 2; p++) active[p] = 1'b0;
        freeAt = 0;
        lastDma = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;

        queueTxn(1, 1'b0, 12'h021, 16'h0, 1'b0);
        queueTxn(0, 1'b0, 12'h010, 16'h0, 1'b0);
        waitIdle(100);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
